multiples_sum: RTL and testbench

Parametrised sum-of-multiples engine: for a run started with limit `max_value`, it adds every integer n with 1 ≤ n < max_value that is divisible by at least one of NUM_DIV run-time-programmable divisors. It generalises the fixed 3/5 accumulator in width, divisor count and divisor value. It adds a start/busy/done handshake, an abort, a hit counter and overflow detection. It sits behind the Euler-problem control/register block as a standalone compute engine.

---
 rtl/multiples_sum.sv | 159 +++++++++++++++
 tb/tb_multiples_sum.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multiples_sum.sv
// multiples_sum: sums every n in [1, max_value) that is divisible by at least
// one of NUM_DIV programmable divisors. One candidate is tested per clock.
// Divisibility is tracked with one modulo counter (residue) per channel, so no
// divider is needed. A zero divisor disables its channel.
module multiples_sum #(
    parameter int CNT_W   = 16,
    parameter int SUM_W   = 32,
    parameter int NUM_DIV = 2,
    parameter int DIV_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         max_value,
    input  logic [NUM_DIV*DIV_W-1:0] divisors,
    output logic                     busy,
    output logic                     results_valid,
    output logic [SUM_W-1:0]         results,
    output logic [CNT_W-1:0]         hits,
    output logic                     overflow
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [SUM_W-1:0] results_q, results_d;
    logic             overflow_q, overflow_d;
    logic [DIV_W-1:0] d_q [NUM_DIV];
    logic [DIV_W-1:0] d_d [NUM_DIV];
    logic [DIV_W-1:0] r_q [NUM_DIV];
    logic [DIV_W-1:0] r_d [NUM_DIV];
    logic [DIV_W-1:0] r_inc [NUM_DIV];
    logic [NUM_DIV-1:0] hit_vec;
    logic             hit;
    logic             accept;
    logic [SUM_W:0]   add_full;

    // A start is only honoured when no run is in flight.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Per-channel hit detection and residue advance (wraps at D-1 back to 0).
    generate
        for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_chan
            assign hit_vec[gi] = (d_q[gi] != '0) && (r_q[gi] == '0);
            assign r_inc[gi]   = (r_q[gi] == d_q[gi] - DIV_W'(1)) ? '0 : r_q[gi] + DIV_W'(1);
        end
    endgenerate

    assign hit = |hit_vec;

    // Extra top bit catches the carry out of the accumulator (assumes SUM_W >= CNT_W).
    assign add_full = {1'b0, results_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, cnt_q};

    // Next-state logic of the control FSM; abort takes priority over termination.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: state_d = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)              state_d = S_IDLE;
                else if (cnt_q >= m_q)  state_d = S_DONE;
            end
            S_DONE: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: latch on accept, initialise in LOAD, step in RUN.
    always_comb begin
        m_d        = m_q;
        cnt_d      = cnt_q;
        hits_d     = hits_q;
        results_d  = results_q;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_DIV; i++) begin
            d_d[i] = d_q[i];
            r_d[i] = r_q[i];
        end

        if (accept) begin
            m_d = max_value;
            for (int i = 0; i < NUM_DIV; i++) begin
                d_d[i] = divisors[i*DIV_W +: DIV_W];
            end
        end

        if ((state_q == S_LOAD) || (state_q == S_RUN)) begin
            if (abort) begin
                results_d  = '0;
                hits_d     = '0;
                overflow_d = 1'b0;
            end else if (state_q == S_LOAD) begin
                cnt_d      = CNT_W'(1);
                results_d  = '0;
                hits_d     = '0;
                overflow_d = 1'b0;
                for (int i = 0; i < NUM_DIV; i++) begin
                    r_d[i] = (d_q[i] == DIV_W'(1)) ? '0 : DIV_W'(1);
                end
            end else if (cnt_q < m_q) begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int i = 0; i < NUM_DIV; i++) begin
                    r_d[i] = r_inc[i];
                end
                if (hit) begin
                    results_d  = add_full[SUM_W-1:0];
                    hits_d     = hits_q + CNT_W'(1);
                    overflow_d = overflow_q | add_full[SUM_W];
                end
            end
        end
    end

    // Control and scalar datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            cnt_q      <= '0;
            hits_q     <= '0;
            results_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            hits_q     <= hits_d;
            results_q  <= results_d;
            overflow_q <= overflow_d;
        end
    end

    // Per-channel divisor and residue registers.
    generate
        for (genvar gi = 0; gi < NUM_DIV; gi++) begin : g_chan_reg
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    d_q[gi] <= '0;
                    r_q[gi] <= '0;
                end else begin
                    d_q[gi] <= d_d[gi];
                    r_q[gi] <= r_d[gi];
                end
            end
        end
    endgenerate

    assign busy          = (state_q == S_LOAD) || (state_q == S_RUN);
    assign results_valid = (state_q == S_DONE);
    assign results       = results_q;
    assign hits          = hits_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_multiples_sum.sv
// Bench for multiples_sum: a default-width instance and a SUM_W=16 instance run
// in lockstep on shared inputs. Expected results come from a direct modulo model
// pushed to a scoreboard at each start and popped when results_valid rises.
module tb_multiples_sum;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] max_value;
    logic [15:0] divisors;
    logic        busy, results_valid, overflow;
    logic [31:0] results;
    logic [15:0] hits;
    logic        busy16, valid16, overflow16;
    logic [15:0] results16;
    logic [15:0] hits16;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] res;
        logic [15:0] hits;
        logic        ovf;
        logic [15:0] res16;
        logic        ovf16;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multiples_sum #(.CNT_W(16), .SUM_W(32), .NUM_DIV(2), .DIV_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .max_value(max_value), .divisors(divisors),
        .busy(busy), .results_valid(results_valid), .results(results),
        .hits(hits), .overflow(overflow)
    );

    multiples_sum #(.CNT_W(16), .SUM_W(16), .NUM_DIV(2), .DIV_W(8)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .max_value(max_value), .divisors(divisors),
        .busy(busy16), .results_valid(valid16), .results(results16),
        .hits(hits16), .overflow(overflow16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            passed++;
    endtask

    // Reference: plain modulo test over every candidate.
    function automatic void model(input int m, input int d0, input int d1,
                                  output longint sum, output int h);
        sum = 0;
        h   = 0;
        for (int n = 1; n < m; n++) begin
            if ((d0 != 0 && n % d0 == 0) || (d1 != 0 && n % d1 == 0)) begin
                sum += n;
                h++;
            end
        end
    endfunction

    // Pulse start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch(input int m, input int d0, input int d1, input bit push);
        exp_t   e;
        longint s;
        int     h;
        @(negedge clk);
        max_value = 16'(m);
        divisors  = {8'(d1), 8'(d0)};
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) begin
            model(m, d0, d1, s, h);
            e.res   = s[31:0];
            e.hits  = 16'(h);
            e.ovf   = (s >= 64'h1_0000_0000);
            e.res16 = s[15:0];
            e.ovf16 = (s >= 64'h1_0000);
            e.lat   = ((m == 0) ? 1 : m) + 1;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for results_valid, then pop and compare.
    task automatic wait_done(input string name, input bit chk_lat);
        int   lat  = 0;
        int   bcnt = 0;
        exp_t e;
        while (!results_valid && lat < 5000) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({name, "_valid"}, results_valid, 1);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (chk_lat) begin
            check({name, "_latency"}, lat, e.lat);
            check({name, "_busy_cycles"}, bcnt, e.lat);
        end
        check({name, "_results"}, results, e.res);
        check({name, "_hits"}, hits, e.hits);
        check({name, "_overflow"}, overflow, e.ovf);
        check({name, "_busy_done"}, busy, 0);
        check({name, "_results16"}, results16, e.res16);
        check({name, "_overflow16"}, overflow16, e.ovf16);
        $display("txn %s: results=%0d hits=%0d ovf=%0d res16=%0d ovf16=%0d latency=%0d",
                 name, results, hits, overflow, results16, overflow16, lat);
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        max_value = '0;
        divisors  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", results_valid, 0);
        check("reset_results", results, 0);
        check("reset_hits", hits, 0);
        check("reset_overflow", overflow, 0);
        reset_n = 1'b1;

        launch(10, 3, 5, 1);    wait_done("d35_m10", 1);
        launch(1000, 3, 5, 1);  wait_done("d35_m1000", 1);
        launch(10, 3, 0, 1);    wait_done("d30_m10", 1);
        launch(10, 1, 7, 1);    wait_done("d17_m10", 1);
        launch(13, 4, 4, 1);    wait_done("d44_m13", 1);
        launch(0, 3, 5, 1);     wait_done("m0", 1);
        launch(1, 3, 5, 1);     wait_done("m1", 1);
        launch(10, 0, 0, 1);    wait_done("d00_m10", 1);

        // Start with new inputs mid-run must be ignored.
        launch(100, 3, 5, 1);
        repeat (30) @(negedge clk);
        max_value = 16'd50;
        divisors  = {8'd11, 8'd7};
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrun_start", 0);

        // Abort at RUN cycle 20.
        launch(100, 3, 5, 0);
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_results", results, 0);
        check("abort_hits", hits, 0);
        check("abort_overflow", overflow, 0);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (results_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        $display("txn abort: results=%0d hits=%0d valid_seen=%0d", results, hits, seen);

        // Asynchronous reset between edges in the middle of a run.
        launch(1000, 3, 5, 0);
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", results_valid, 0);
        check("arst_results", results, 0);
        check("arst_hits", hits, 0);
        check("arst_overflow", overflow, 0);
        $display("txn async_reset: results=%0d hits=%0d busy=%0d", results, hits, busy);
        @(negedge clk);
        reset_n = 1'b1;
        launch(10, 3, 5, 1);    wait_done("after_reset", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
